mem_port_arbiter: RTL
=====================

# mem_port_arbiter

- Shares one single-outstanding memory port between the instruction-fetch requester (IF) and the data-access requester (DM), and stalls the pipeline until the owning transaction completes.
- DM is driven by MemRead/MemWrite decoded for LW/LB/SW/FLW/FSW; IF is the PC fetch.
- Sits between the pipeline and the bus/memory wrapper.
- Includes a watchdog that terminates hung transactions and flags an error.

## Interface
- TIMEOUT, 255: cycles a transaction may stay in REQ+RSP before forced termination; legal range 2..65535.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req  in  1  IF fetch request, level; held until if_done.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched instruction, registered.
- if_done  out  1  one-cycle completion pulse for IF.
- dm_read  in  1  data load request, level; held until dm_done.
- dm_write  in  1  data store request, level; held until dm_done.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_wstrb  in  4  byte strobes.
- dm_rdata  out  32  load data, registered.
- dm_done  out  1  one-cycle completion pulse for DM.
- mem_req_valid  out  1  downstream request valid.
- mem_req_ready  in  1  downstream accepts request.
- mem_req_we  out  1  1 = write.
- mem_req_addr  out  32  request address.
- mem_req_wdata  out  32  write data.
- mem_req_wstrb  out  4  write strobes; 0 for reads.
- mem_rsp_valid  in  1  response valid, one cycle per request; reads and writes.
- mem_rsp_rdata  in  32  response data.
- stall  out  1  pipeline stall.
- bus_err  out  1  sticky timeout flag, cleared only by reset.

## Operation
- FSM states:
  - IDLE: no transaction.
  - REQ: mem_req_valid=1.
  - RSP: awaiting mem_rsp_valid.
- IDLE arbitration:
  - dm_req = dm_read|dm_write.
  - dm_req has fixed priority over if_req.
  - A requester whose done is high this cycle is ignored.
  - The winner's addr/we/wdata/wstrb and the owner are latched; go to REQ.
  - dm_read and dm_write both high: treated as write.
- REQ:
  - mem_req_* are driven from the latched registers; they stay stable while valid=1 and ready=0.
  - When ready=1, go to RSP.
- RSP:
  - When mem_rsp_valid=1, capture rdata into the owner's rdata register. Writes also update dm_rdata with the response data.
  - Pulse the owner's done next cycle; go to IDLE.
- mem_rsp_valid outside RSP is ignored. Downstream guarantees the response arrives at least 1 cycle after the handshake.
- Watchdog:
  - 16-bit counter, cleared on entry to REQ; increments in REQ/RSP.
  - When it reaches TIMEOUT-1 without completion, the FSM goes to IDLE, the owner's done pulses, the owner's rdata = 0, and bus_err is set.
- stall = (if_req & ~if_done) | (dm_req & ~dm_done). Combinational from inputs and registered done.
- Reset values: all outputs 0; FSM = IDLE; owner = IF; watchdog = 0.

## Timing
- Best case, request seen in IDLE at cycle 0:
  - REQ at cycle 1 with ready=1.
  - RSP at cycle 2 with rsp_valid=1.
  - done at cycle 3.
  - Minimum latency: 3 cycles from request to done.
- Throughput: one transaction per 3 cycles minimum. The requester may hold its request across done, but a same-requester re-grant occurs only when done=0.
- A DM request arriving while an IF transaction is active waits; it wins at the next IDLE.
- Reset mid-transaction:
  - Outputs drop asynchronously; no done pulse is issued.
  - The downstream must tolerate valid dropping only under reset.
- Data ownership:
  - if_rdata and dm_rdata hold their value until overwritten by their own owner's next completion.
  - The done pulse is exactly 1 cycle.

## Structure
- Package mem_arb_pkg:
  - state enum {IDLE, REQ, RSP}.
  - owner enum {OWN_IF, OWN_DM}.
  - TIMEOUT width localparam (16).
- Sub-module arb_watchdog:
  - Inputs: clear/enable.
  - Output: expire.
  - Parameter: TIMEOUT.
- Everything else is in the top module.

## Test plan
- IF read: if_req, addr 0x0000_0010; ready immediate; rsp 0x0000_0013 one cycle later -> if_done pulse at cycle 3, if_rdata=0x0000_0013, stall high cycles 0-2.
- Collision: if_req and dm_read (addr 0x0001_0000) raised same cycle -> DM granted first (mem_req_addr=0x0001_0000, we=0); IF request issued after dm_done; dm_rdata correct.
- Store with backpressure: dm_write, addr 0x0001_0004, wdata 0xDEAD_BEEF, wstrb 4'b0011, ready low 4 cycles -> mem_req_* stable all 4 cycles; dm_done one cycle after rsp_valid.
- Timeout: TIMEOUT=8, ready never asserted -> forced completion on the 8th REQ/RSP cycle; dm_done pulses; dm_rdata=0; bus_err=1 and stays 1.
- Reset mid-RSP: assert rst_n=0 during RSP -> all outputs 0 immediately; after release, the next request completes normally with bus_err=0.
- Back-to-back IF: if_req held high across 3 fetches -> no grant in done cycles; exactly 3 done pulses, each ≥3 cycles apart.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter slice.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RSP
   } state_t;

   typedef enum logic {
      OWN_IF,
      OWN_DM
   } owner_t;

   // Width of the transaction watchdog counter
   localparam int unsigned TO_W = 16;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Transaction watchdog: counts cycles spent in REQ/RSP and flags expiry
// on the TIMEOUT-th cycle of a transaction.
module arb_watchdog
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] cnt;

   assign expire = enable & (cnt == LIMIT);

   // Cycle counter: restarts at grant, advances while a transaction is open
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !expire) begin
         cnt <= cnt + TO_W'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between instruction fetch (IF)
// and data access (DM). DM has fixed priority; a watchdog forces completion
// of hung transactions and raises a sticky bus_err.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_done,
   input  logic        dm_read,
   input  logic        dm_write,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [3:0]  dm_wstrb,
   output logic [31:0] dm_rdata,
   output logic        dm_done,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wstrb,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata,
   output logic        stall,
   output logic        bus_err
);

   state_t      st;
   owner_t      owner;
   logic        dm_req;
   logic        dm_go;
   logic        if_go;
   logic        wd_clear;
   logic        wd_en;
   logic        expire;
   logic        fin_ok;
   logic        fin_to;
   logic [31:0] fin_data;

   assign dm_req = dm_read | dm_write;
   // A requester whose done pulse is high this cycle is not re-granted
   assign dm_go  = dm_req & ~dm_done;
   assign if_go  = if_req & ~if_done;

   assign wd_clear = (st == IDLE) & (dm_go | if_go);
   assign wd_en    = (st != IDLE);

   // Normal completion beats a coincident watchdog expiry
   assign fin_ok   = (st == RSP) & mem_rsp_valid;
   assign fin_to   = expire & ~fin_ok;
   assign fin_data = fin_ok ? mem_rsp_rdata : '0;

   assign mem_req_valid = (st == REQ);
   assign stall         = (if_req & ~if_done) | (dm_req & ~dm_done);

   arb_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_wd (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (wd_clear),
      .enable(wd_en),
      .expire(expire)
   );

   // Arbitration, request latching, completion capture and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st            <= IDLE;
         owner         <= OWN_IF;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         mem_req_wstrb <= '0;
         if_rdata      <= '0;
         dm_rdata      <= '0;
         if_done       <= 1'b0;
         dm_done       <= 1'b0;
         bus_err       <= 1'b0;
      end else begin
         if_done <= 1'b0;
         dm_done <= 1'b0;
         case (st)
            IDLE: begin
               if (dm_go) begin
                  owner         <= OWN_DM;
                  mem_req_we    <= dm_write;
                  mem_req_addr  <= dm_addr;
                  mem_req_wdata <= dm_write ? dm_wdata : '0;
                  mem_req_wstrb <= dm_write ? dm_wstrb : '0;
                  st            <= REQ;
               end else if (if_go) begin
                  owner         <= OWN_IF;
                  mem_req_we    <= 1'b0;
                  mem_req_addr  <= if_addr;
                  mem_req_wdata <= '0;
                  mem_req_wstrb <= '0;
                  st            <= REQ;
               end
            end
            REQ: begin
               if (fin_to) begin
                  st <= IDLE;
               end else if (mem_req_ready) begin
                  st <= RSP;
               end
            end
            RSP: begin
               if (fin_ok || fin_to) begin
                  st <= IDLE;
               end
            end
            default: st <= IDLE;
         endcase
         if (fin_ok || fin_to) begin
            if (owner == OWN_DM) begin
               dm_rdata <= fin_data;
               dm_done  <= 1'b1;
            end else begin
               if_rdata <= fin_data;
               if_done  <= 1'b1;
            end
         end
         if (fin_to) begin
            bus_err <= 1'b1;
         end
      end
   end

endmodule
